bit_slice_1bit: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/full_adder_1bit.sv | 14 +
 rtl/bit_slice_1bit.sv | 68 ++++++
 tb/tb_bit_slice_1bit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Operation codes and B-invert decode shared by the ALU slice and its parent.
// Pure definitions: no logic, no latency.
package alu_pkg;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_XOR = 3'b010;
  localparam logic [2:0] CTRL_SLT = 3'b011;
  localparam logic [2:0] CTRL_MUL = 3'b100;

  // SLT runs the adder as a subtract so the MSB set bit gives the sign of a-b.
  function automatic logic ctrl_is_sub(input logic [2:0] ctrl);
    return (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT);
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder for the ALU ripple chain.
// Purely combinational, zero latency, no flow control.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_slice_1bit.sv
// One-bit ALU slice: B-invert, full adder, result mux and registered result bit.
// Carry/set/ovf combinational; out updates one edge after res when en=1, else holds.
module bit_slice_1bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] ctrl,
  output logic       out,
  output logic       cout,
  output logic       set,
  output logic       ovf
);

  logic bx;
  logic sum;
  logic res;
  logic out_d;
  logic out_q;

  assign bx = b ^ ctrl_is_sub(ctrl);

  full_adder_1bit u_fa (
    .a    (a),
    .b    (bx),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  assign set = sum;
  assign ovf = cin ^ cout;

  always_comb begin
    res = 1'b0;
    case (ctrl)
      CTRL_ADD: res = sum;
      CTRL_SUB: res = sum;
      CTRL_XOR: res = a ^ b;
      CTRL_SLT: res = less;
      CTRL_MUL: res = a & b;
      default:  res = 1'b0;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_bit_slice_1bit.sv
// Directed bench for bit_slice_1bit: combinational outputs checked against a
// reference model, registered result checked through an expected-value queue.
module tb_bit_slice_1bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a;
  logic       b;
  logic       cin;
  logic       less;
  logic [2:0] ctrl;
  logic       out;
  logic       cout;
  logic       set;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  logic exp_q[$];
  logic model_q;

  always #5 clk = ~clk;

  bit_slice_1bit dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .less (less),
    .ctrl (ctrl),
    .out  (out),
    .cout (cout),
    .set  (set),
    .ovf  (ovf)
  );

  // Reference: returns {cout, set, ovf, res}
  function automatic logic [3:0] model(input logic ma, input logic mb, input logic mc,
                                       input logic ml, input logic [2:0] mctrl);
    logic mbx, msum, mcout, mres;
    mbx   = mb ^ ((mctrl == 3'b001) || (mctrl == 3'b011));
    msum  = ma ^ mbx ^ mc;
    mcout = (ma & mbx) | (ma & mc) | (mbx & mc);
    case (mctrl)
      3'b000:  mres = msum;
      3'b001:  mres = msum;
      3'b010:  mres = ma ^ mb;
      3'b011:  mres = ml;
      3'b100:  mres = ma & mb;
      default: mres = 1'b0;
    endcase
    return {mcout, msum, mc ^ mcout, mres};
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one operation, check comb outputs, clock once, check registered out.
  task automatic step(input string tag, input logic sa, input logic sb, input logic sc,
                      input logic sl, input logic [2:0] sctrl, input logic sen);
    logic [3:0] m;
    logic       e;
    a = sa; b = sb; cin = sc; less = sl; ctrl = sctrl; en = sen;
    #2;
    m = model(sa, sb, sc, sl, sctrl);
    chk({tag, ".cout"}, cout, m[3]);
    chk({tag, ".set"},  set,  m[2]);
    chk({tag, ".ovf"},  ovf,  m[1]);
    if (sen) model_q = m[0];
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".out"}, out, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0; less = 1'b0; ctrl = 3'b000;
    model_q = 1'b0;
    #3;
    chk("reset.out", out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load a 1, then assert reset mid-cycle: out must drop immediately.
    step("rst_load", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async.out", out, 1'b0);
    model_q = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      step($sformatf("add%0d", i), v[2], v[1], v[0], 1'b0, 3'b000, 1'b1);
    end

    step("sub_11", 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1);
    step("sub_01", 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1);

    step("xor_11", 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
    step("mul_11", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
    step("xor_10", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    step("mul_10", 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);

    step("slt_l1", 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
    step("slt_l0", 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1);
    step("slt_l1b", 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
    step("rsv_111", 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1);

    // Enable hold: load 1, then three disabled edges with res = 0.
    step("hold_load", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
    end
    step("hold_release", 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
